// File: rtl/ntt_loop_sequencer_pkg.sv
// Shared types and defaults for the NTT loop sequencer.
// Sized helpers let the parent and sub-module agree on stage bounds.
package ntt_loop_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int DEF_N         = 256;
    localparam int DEF_N_BITS    = 8;
    localparam int DEF_STAGE_GAP = 4;

    function automatic int beats_per_stage(input int n);
        return n / 4;
    endfunction

    function automatic int last_stage(input int n_bits);
        return n_bits - 1;
    endfunction

    localparam int BEATS_PER_STAGE = beats_per_stage(DEF_N);
    localparam int LAST_STAGE      = last_stage(DEF_N_BITS);

endpackage

// File: rtl/ntt_stage_iter.sv
// Per-stage group/offset walker: j steps by 2h per group, k runs 0..h-1.
// Stages 0 and 1 behave as h=1, giving j=counter stepping by 2.
module ntt_stage_iter
    import ntt_loop_sequencer_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int N_bits = DEF_N_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_bits:0]   i,
    input  logic              advance,
    input  logic              clear,
    output logic [N_bits:0]   j,
    output logic [N_bits:0]   counter,
    output logic [N_bits:0]   current_pair,
    output logic              last_beat
);

    localparam int W = N_bits + 1;
    localparam logic [W-1:0] HALF = W'(N / 2);

    logic [W-1:0] h;
    logic [W-1:0] j_q;
    logic [W-1:0] k_q;
    logic         k_wrap;

    always_comb begin
        h = W'(1);
        if (i >= W'(2)) begin
            h = W'(1) << (i - W'(1));
        end
    end

    assign k_wrap    = (k_q == h - W'(1));
    assign last_beat = k_wrap && (j_q == HALF - (h << 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            j_q <= '0;
            k_q <= '0;
        end else if (advance && !last_beat) begin
            if (k_wrap) begin
                k_q <= '0;
                j_q <= j_q + (h << 1);
            end else begin
                k_q <= k_q + W'(1);
            end
        end
    end

    assign j            = j_q;
    assign counter      = j_q + k_q;
    assign current_pair = k_q << 1;

endmodule

// File: rtl/ntt_loop_sequencer.sv
// Stage-level FSM for the NTT/INTT address pipeline: issues N/4 beats
// per stage, drains STAGE_GAP cycles between stages, then pulses done.
module ntt_loop_sequencer
    import ntt_loop_sequencer_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int N_bits    = DEF_N_BITS,
    parameter int STAGE_GAP = DEF_STAGE_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              intt_mode,
    input  logic              hold,
    output logic              enable,
    output logic              is_intt,
    output logic [N_bits:0]   i,
    output logic [N_bits:0]   j,
    output logic [N_bits:0]   m,
    output logic [N_bits:0]   counter,
    output logic [N_bits:0]   current_pair,
    output logic              busy,
    output logic              stage_done,
    output logic              done
);

    localparam int W  = N_bits + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam logic [W-1:0] LAST = W'(last_stage(N_bits));

    seq_state_t    state;
    logic [GW-1:0] gap_q;
    logic [W-1:0]  i_q;
    logic [W-1:0]  m_q;
    logic          intt_q;
    logic          busy_q;
    logic          done_q;

    logic          beat;
    logic          last_beat;
    logic          gap_end;
    logic          final_stage;
    logic          clear;
    logic [W-1:0]  i_first;
    logic [W-1:0]  i_next;

    assign beat        = (state == RUN) && !hold;
    assign gap_end     = (gap_q == GW'(STAGE_GAP - 1));
    assign final_stage = intt_q ? (i_q == '0) : (i_q == LAST);
    assign i_first     = intt_mode ? LAST : '0;
    assign i_next      = intt_q ? i_q - W'(1) : i_q + W'(1);
    assign clear       = ((state == IDLE) && start)
                      || ((state == DRAIN) && gap_end && !final_stage);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gap_q  <= '0;
            i_q    <= '0;
            m_q    <= '0;
            intt_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        intt_q <= intt_mode;
                        i_q    <= i_first;
                        m_q    <= W'(2) << i_first;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (beat && last_beat) begin
                        gap_q <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!gap_end) begin
                        gap_q <= gap_q + GW'(1);
                    end else if (final_stage) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        i_q   <= i_next;
                        m_q   <= W'(2) << i_next;
                        state <= RUN;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ntt_stage_iter #(
        .N      (N),
        .N_bits (N_bits)
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .i            (i_q),
        .advance      (beat),
        .clear        (clear),
        .j            (j),
        .counter      (counter),
        .current_pair (current_pair),
        .last_beat    (last_beat)
    );

    assign enable     = beat;
    assign stage_done = beat && last_beat;
    assign is_intt    = intt_q;
    assign i          = i_q;
    assign m          = m_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ntt_loop_sequencer.sv
// Bench for ntt_loop_sequencer: beat-list scoreboard built from the
// stage/group/offset rules, plus fixed vectors and reset/hold sequences.
module tb_ntt_loop_sequencer;
    import ntt_loop_sequencer_pkg::*;

    localparam int N        = 256;
    localparam int NB       = 8;
    localparam int GAP      = 4;
    localparam int W        = NB + 1;
    localparam int BASE_LAT = NB * (N / 4 + GAP) + 1;
    localparam int NO_HOLD  = 100000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         intt_mode;
    logic         hold;
    logic         enable;
    logic         is_intt;
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic [W-1:0] m;
    logic [W-1:0] counter;
    logic [W-1:0] current_pair;
    logic         busy;
    logic         stage_done;
    logic         done;

    ntt_loop_sequencer #(
        .N         (N),
        .N_bits    (NB),
        .STAGE_GAP (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .intt_mode    (intt_mode),
        .hold         (hold),
        .enable       (enable),
        .is_intt      (is_intt),
        .i            (i),
        .j            (j),
        .m            (m),
        .counter      (counter),
        .current_pair (current_pair),
        .busy         (busy),
        .stage_done   (stage_done),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int i;
        int j;
        int m;
        int c;
        int p;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int cap_c[NB][N/4];
    int cap_j[NB][N/4];
    int cap_p[NB][N/4];
    int cap_m[NB][N/4];
    int cap_n[NB];

    function automatic logic [5*W-1:0] pk(input int a, input int b,
                                          input int c, input int d,
                                          input int e);
        return {W'(a), W'(b), W'(c), W'(d), W'(e)};
    endfunction

    function automatic logic [5*W-1:0] dut_beat();
        return pk(int'(i), int'(j), int'(m), int'(counter),
                  int'(current_pair));
    endfunction

    // Expected beat list straight from the stage rules.
    task automatic build(input bit intt);
        exp_q.delete();
        for (int s = 0; s < NB; s++) begin
            int st;
            int mm;
            st = intt ? NB - 1 - s : s;
            mm = 2 << st;
            if (st < 2) begin
                for (int c = 0; c < N / 2; c += 2)
                    exp_q.push_back('{st, c, mm, c, 0, (c == N/2 - 2)});
            end else begin
                int h;
                int ng;
                h  = 1 << (st - 1);
                ng = (N / 2) / (2 * h);
                for (int g = 0; g < ng; g++)
                    for (int k = 0; k < h; k++)
                        exp_q.push_back('{st, g*2*h, mm, g*2*h + k, 2*k,
                                          (g == ng-1 && k == h-1)});
            end
        end
    endtask

    task automatic run_check(input bit intt, input int hold_pct,
                             input int hold_at, input int hold_len,
                             input int busy_at, output int nbeats,
                             output int nsd, output int lat,
                             output int held);
        int phase;
        int ph;
        int gap_left;
        beat_t lb;
        beat_t b;
        bit hv;
        bit exp_en;
        build(intt);
        nbeats = 0;
        nsd    = 0;
        lat    = -1;
        held   = 0;
        for (int s = 0; s < NB; s++) cap_n[s] = 0;
        lb = '{0, 0, 0, 0, 0, 1'b0};
        @(negedge clk);
        start     = 1'b1;
        intt_mode = intt;
        hold      = 1'b0;
        @(posedge clk);
        phase    = 0;
        gap_left = 0;
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            start     = (g == busy_at);
            intt_mode = ~intt;
            hv = (g >= hold_at && g < hold_at + hold_len)
              || (int'($urandom_range(99)) < hold_pct);
            hold = hv;
            #1;
            ph = phase;
            if (ph == 3) begin
                chk("idle_busy", 64'(busy), 64'(0));
                chk("idle_done", 64'(done), 64'(0));
                break;
            end
            chk("busy", 64'(busy), 64'(1));
            chk("done", 64'(done), 64'(ph == 2));
            chk("is_intt", 64'(is_intt), 64'(intt));
            exp_en = (ph == 0) && !hv;
            chk("enable", 64'(enable), 64'(exp_en));
            if (ph == 0 && hv) held++;
            if (exp_en) begin
                b = exp_q.pop_front();
                chk("beat", 64'(dut_beat()), 64'(pk(b.i, b.j, b.m, b.c, b.p)));
                chk("stage_done", 64'(stage_done), 64'(b.last));
                nbeats++;
                nsd += int'(stage_done);
                if (!intt && i < W'(NB) && cap_n[i] < N / 4) begin
                    cap_c[i][cap_n[i]] = int'(counter);
                    cap_j[i][cap_n[i]] = int'(j);
                    cap_p[i][cap_n[i]] = int'(current_pair);
                    cap_m[i][cap_n[i]] = int'(m);
                    cap_n[i]++;
                end
                lb = b;
                if (b.last) begin
                    phase    = 1;
                    gap_left = GAP;
                end
            end else begin
                chk("stage_done_idle", 64'(stage_done), 64'(0));
                nsd += int'(stage_done);
                if (ph == 0)
                    chk("frozen", 64'(dut_beat()),
                        64'(pk(exp_q[0].i, exp_q[0].j, exp_q[0].m,
                               exp_q[0].c, exp_q[0].p)));
                else
                    chk("drain_hold", 64'(dut_beat()),
                        64'(pk(lb.i, lb.j, lb.m, lb.c, lb.p)));
            end
            if (ph == 1) begin
                gap_left--;
                if (gap_left == 0) phase = (exp_q.size() == 0) ? 2 : 0;
            end
            if (ph == 2) begin
                lat   = g + 1;
                phase = 3;
            end
        end
        chk("run_finished", 64'(phase), 64'(3));
        start = 1'b0;
        hold  = 1'b0;
    endtask

    typedef struct {
        int st;
        int idx;
        int c;
        int j;
        int p;
        int m;
    } vec_t;

    typedef struct {
        bit intt;
        int hold_pct;
        int hold_at;
        int hold_len;
        int busy_at;
        int exp_beats;
        int exp_sd;
        int exp_lat;
    } run_t;

    vec_t vt[12];
    run_t rt[6];

    initial begin
        int nb;
        int ns;
        int lat;
        int held;
        int dcnt;
        reset     = 1'b1;
        start     = 1'b0;
        intt_mode = 1'b0;
        hold      = 1'b0;

        vt[0]  = '{2, 0, 0, 0, 0, 8};
        vt[1]  = '{2, 1, 1, 0, 2, 8};
        vt[2]  = '{2, 2, 4, 4, 0, 8};
        vt[3]  = '{2, 3, 5, 4, 2, 8};
        vt[4]  = '{2, 4, 8, 8, 0, 8};
        vt[5]  = '{2, 5, 9, 8, 2, 8};
        vt[6]  = '{7, 0, 0, 0, 0, 256};
        vt[7]  = '{7, 1, 1, 0, 2, 256};
        vt[8]  = '{7, 63, 63, 0, 126, 256};
        vt[9]  = '{0, 63, 126, 126, 0, 2};
        vt[10] = '{3, 7, 11, 8, 6, 16};
        vt[11] = '{6, 33, 65, 64, 2, 128};

        rt[0] = '{1'b0, 0, NO_HOLD, 0, NO_HOLD, 512, 8, 545};
        rt[1] = '{1'b1, 0, NO_HOLD, 0, NO_HOLD, 512, 8, 545};
        rt[2] = '{1'b0, 0, 234, 3, NO_HOLD, 512, 8, 548};
        rt[3] = '{1'b0, 0, NO_HOLD, 0, 50, 512, 8, 545};
        rt[4] = '{1'b1, 20, NO_HOLD, 0, NO_HOLD, 512, 8, -1};
        rt[5] = '{1'b0, 30, NO_HOLD, 0, 300, 512, 8, -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({enable, is_intt, i, j, m, counter,
            current_pair, busy, stage_done, done}), 64'(0));
        reset = 1'b0;
        hold  = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 64'({enable, busy, stage_done, done}), 64'(0));
        hold = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_check(rt[r].intt, rt[r].hold_pct, rt[r].hold_at,
                      rt[r].hold_len, rt[r].busy_at, nb, ns, lat, held);
            chk($sformatf("run%0d_beats", r), 64'(nb), 64'(rt[r].exp_beats));
            chk($sformatf("run%0d_stage_done", r), 64'(ns), 64'(rt[r].exp_sd));
            chk($sformatf("run%0d_latency", r), 64'(lat),
                64'(BASE_LAT + held));
            if (rt[r].exp_lat >= 0)
                chk($sformatf("run%0d_fixed_latency", r), 64'(lat),
                    64'(rt[r].exp_lat));
            if (r == 0) begin
                for (int v = 0; v < 12; v++)
                    chk($sformatf("vec%0d_s%0d_b%0d", v, vt[v].st, vt[v].idx),
                        64'(pk(cap_c[vt[v].st][vt[v].idx],
                               cap_j[vt[v].st][vt[v].idx],
                               cap_p[vt[v].st][vt[v].idx],
                               cap_m[vt[v].st][vt[v].idx], 0)),
                        64'(pk(vt[v].c, vt[v].j, vt[v].p, vt[v].m, 0)));
            end
        end

        // Abort mid-run with reset, then restart cleanly.
        @(negedge clk);
        start     = 1'b1;
        intt_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs", 64'({enable, is_intt, i, j, m, counter,
            current_pair, busy, stage_done, done}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        dcnt  = 0;
        for (int g = 0; g < 600; g++) begin
            @(negedge clk);
            hold = 1'(int'($urandom_range(1)));
            dcnt += int'(done) + int'(enable);
        end
        hold = 1'b0;
        chk("abort_no_activity", 64'(dcnt), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        run_check(1'b0, 0, NO_HOLD, 0, NO_HOLD, nb, ns, lat, held);
        chk("restart_beats", 64'(nb), 64'(512));
        chk("restart_latency", 64'(lat), 64'(545));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
